// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single MSP430 memory bus (MAB/MDB) between the instruction
//   fetch port and the execute-stage data port. Each access runs through
//   IDLE -> ACCESS -> DONE. Grant is issued combinationally in IDLE. The bus
//   is driven for 1+WAIT_STATES cycles. Acknowledge and read data follow in
//   the next cycle.
//
//   Handshake (both ports): a requester raises req with its address and
//   controls and holds them stable until ack. gnt pulses for one cycle when
//   the access starts. ack pulses for one cycle when it completes, with
//   rdata valid at that point. req seen high in IDLE always starts a new
//   access, so the requester drops req or presents its next request in the
//   cycle after ack.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   fetch_req/addr                 fetch request (always a word read)
//   fetch_gnt/ack/rdata            fetch grant pulse, ack pulse, read word
//   data_req/we/bw/addr/wdata      data request, write, byte, address, wdata
//   data_gnt/ack/rdata             data grant pulse, ack pulse, read data
//   MAB, MDB_out, MDB_in           memory address, write data, read data
//   mem_re, mem_we[1:0]            read strobe, write byte enables (hi, lo)
//   busy                           FSM not in IDLE
//   dbg_state                      current FSM state encoding
module mem_bus_arbiter #(
   parameter int WAIT_STATES     = 0,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [15:0] fetch_addr,
   output logic        fetch_gnt,
   output logic        fetch_ack,
   output logic [15:0] fetch_rdata,
   input  logic        data_req,
   input  logic        data_we,
   input  logic        data_bw,
   input  logic [15:0] data_addr,
   input  logic [15:0] data_wdata,
   output logic        data_gnt,
   output logic        data_ack,
   output logic [15:0] data_rdata,
   output logic [15:0] MAB,
   output logic [15:0] MDB_out,
   input  logic [15:0] MDB_in,
   output logic        mem_re,
   output logic [1:0]  mem_we,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   localparam int SW = $clog2(MAX_DATA_STREAK + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t         state, state_n;
   logic [3:0]     wait_cnt;
   logic [SW-1:0]  streak;
   logic           sel_data, sel_we, sel_bw, sel_odd;

   logic           pick_fetch, pick_data;
   logic [15:0]    acc_addr;
   logic           acc_we, acc_bw;
   logic [15:0]    next_mab, next_mdb;
   logic [1:0]     next_mwe;

   // Next state and arbitration. Data wins ties unless it has already taken
   // MAX_DATA_STREAK grants in a row while fetch was waiting.
   always_comb begin
      state_n    = state;
      pick_fetch = 1'b0;
      pick_data  = 1'b0;
      unique case (state)
         IDLE: begin
            if (data_req && !(fetch_req && streak == SW'(MAX_DATA_STREAK)))
               pick_data = 1'b1;
            else if (fetch_req)
               pick_fetch = 1'b1;
            if (pick_data || pick_fetch)
               state_n = ACCESS;
         end
         ACCESS: begin
            if (wait_cnt == 4'd0)
               state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Bus values for the access being granted this cycle.
   always_comb begin
      acc_addr = pick_data ? data_addr : fetch_addr;
      acc_we   = pick_data & data_we;
      acc_bw   = pick_data & data_bw;
      next_mab = acc_bw ? acc_addr : {acc_addr[15:1], 1'b0};
      next_mdb = 16'h0000;
      next_mwe = 2'b00;
      if (acc_we) begin
         next_mdb = acc_bw ? {2{data_wdata[7:0]}} : data_wdata;
         next_mwe = acc_bw ? (acc_addr[0] ? 2'b10 : 2'b01) : 2'b11;
      end
   end

   // Grants are combinational; masking with rst keeps a grant from being
   // reported for a cycle whose state update the reset discards.
   assign fetch_gnt = pick_fetch & ~rst;
   assign data_gnt  = pick_data  & ~rst;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= 4'd0;
         streak      <= '0;
         sel_data    <= 1'b0;
         sel_we      <= 1'b0;
         sel_bw      <= 1'b0;
         sel_odd     <= 1'b0;
         MAB         <= 16'h0000;
         MDB_out     <= 16'h0000;
         mem_re      <= 1'b0;
         mem_we      <= 2'b00;
         fetch_ack   <= 1'b0;
         data_ack    <= 1'b0;
         fetch_rdata <= 16'h0000;
         data_rdata  <= 16'h0000;
      end else begin
         state     <= state_n;
         fetch_ack <= 1'b0;
         data_ack  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pick_fetch || pick_data) begin
                  sel_data <= pick_data;
                  sel_we   <= acc_we;
                  sel_bw   <= acc_bw;
                  sel_odd  <= acc_addr[0];
                  wait_cnt <= 4'(WAIT_STATES);
                  MAB      <= next_mab;
                  MDB_out  <= next_mdb;
                  mem_re   <= ~acc_we;
                  mem_we   <= next_mwe;
                  // Streak only counts data grants that made fetch wait.
                  streak   <= (pick_data && fetch_req) ? streak + SW'(1) : '0;
               end
            end
            ACCESS: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  MAB     <= 16'h0000;
                  MDB_out <= 16'h0000;
                  mem_re  <= 1'b0;
                  mem_we  <= 2'b00;
                  if (sel_data) data_ack  <= 1'b1;
                  else          fetch_ack <= 1'b1;
                  // Read data is captured on the last bus cycle, while
                  // MDB_in is still valid under mem_re.
                  if (!sel_we) begin
                     if (!sel_data)
                        fetch_rdata <= MDB_in;
                     else if (sel_bw)
                        data_rdata <= {8'h00, sel_odd ? MDB_in[15:8] : MDB_in[7:0]};
                     else
                        data_rdata <= MDB_in;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter (WAIT_STATES=2, MAX_DATA_STREAK=4). The
// reference model works on a transaction timeline: a grant at cycle g
// drives the bus during g+1..g+1+W and acks at g+2+W. Every output is
// compared against that timeline each cycle.
module tb_mem_bus_arbiter;

   localparam int W    = 2;
   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req, data_req, data_we, data_bw;
   logic [15:0] fetch_addr, data_addr, data_wdata, MDB_in;
   logic        fetch_gnt, fetch_ack, data_gnt, data_ack, mem_re, busy;
   logic [15:0] fetch_rdata, data_rdata, MAB, MDB_out;
   logic [1:0]  mem_we, dbg_state;

   mem_bus_arbiter #(.WAIT_STATES(W), .MAX_DATA_STREAK(MAXS)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_gnt(fetch_gnt), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
      .data_req(data_req), .data_we(data_we), .data_bw(data_bw),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_gnt(data_gnt), .data_ack(data_ack), .data_rdata(data_rdata),
      .MAB(MAB), .MDB_out(MDB_out), .MDB_in(MDB_in),
      .mem_re(mem_re), .mem_we(mem_we), .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // driver shadow inputs, applied just after each rising edge
   logic        s_rst, f_pend, d_pend, d_we, d_bw;
   logic [15:0] f_addr, d_addr, d_wd, s_mdb;
   bit          rand_mdb;

   // reference model state
   bit          m_act, m_isd, m_we, m_bw;
   int          m_g, m_streak;
   logic [15:0] m_addr, m_wd, m_cap, e_frd, e_drd;
   bit          fack_now, dack_now;

   // grant-order scoreboard (1 = data, 0 = fetch)
   logic [0:0]  exp_q[$];
   logic [0:0]  got_q[$];
   bit          log_on;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_step();
      logic [15:0] e_mab, e_mdb;
      logic [1:0]  e_mwe;
      logic        e_re, bus_on, e_busy;
      fack_now = 0;
      dack_now = 0;
      if (rst) begin
         check_eq("rst_fetch_gnt", 16'(fetch_gnt), 16'h0);
         check_eq("rst_data_gnt", 16'(data_gnt), 16'h0);
         m_act = 0; m_streak = 0; e_frd = 16'h0; e_drd = 16'h0;
         return;
      end
      if (m_act && cyc > m_g + 2 + W) m_act = 0;
      if (!m_act && (fetch_req || data_req)) begin
         m_isd = data_req && !(fetch_req && m_streak == MAXS);
         m_streak = (m_isd && fetch_req) ? m_streak + 1 : 0;
         m_act  = 1;
         m_g    = cyc;
         m_we   = m_isd && data_we;
         m_bw   = m_isd && data_bw;
         m_addr = m_isd ? data_addr : fetch_addr;
         m_wd   = data_wdata;
      end
      bus_on = m_act && cyc >= m_g + 1 && cyc <= m_g + 1 + W;
      e_busy = m_act && cyc >= m_g + 1 && cyc <= m_g + 2 + W;
      e_mab = 16'h0; e_mdb = 16'h0; e_mwe = 2'b00; e_re = 1'b0;
      if (bus_on) begin
         e_mab = m_bw ? m_addr : (m_addr & 16'hFFFE);
         e_re  = !m_we;
         if (m_we) begin
            e_mdb = m_bw ? {m_wd[7:0], m_wd[7:0]} : m_wd;
            e_mwe = m_bw ? (m_addr[0] ? 2'b10 : 2'b01) : 2'b11;
         end
         if (cyc == m_g + 1 + W) m_cap = MDB_in;
      end
      if (m_act && cyc == m_g + 2 + W) begin
         if (m_isd) dack_now = 1; else fack_now = 1;
         if (!m_we) begin
            if (!m_isd)    e_frd = m_cap;
            else if (m_bw) e_drd = {8'h00, m_addr[0] ? m_cap[15:8] : m_cap[7:0]};
            else           e_drd = m_cap;
         end
      end
      check_eq("fetch_gnt", 16'(fetch_gnt), 16'(m_act && cyc == m_g && !m_isd));
      check_eq("data_gnt", 16'(data_gnt), 16'(m_act && cyc == m_g && m_isd));
      check_eq("fetch_ack", 16'(fetch_ack), 16'(fack_now));
      check_eq("data_ack", 16'(data_ack), 16'(dack_now));
      check_eq("MAB", MAB, e_mab);
      check_eq("MDB_out", MDB_out, e_mdb);
      check_eq("mem_re", 16'(mem_re), 16'(e_re));
      check_eq("mem_we", 16'(mem_we), 16'(e_mwe));
      check_eq("busy", 16'(busy), 16'(e_busy));
      check_eq("fetch_rdata", fetch_rdata, e_frd);
      check_eq("data_rdata", data_rdata, e_drd);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      rst = s_rst; fetch_req = f_pend; fetch_addr = f_addr;
      data_req = d_pend; data_we = d_we; data_bw = d_bw;
      data_addr = d_addr; data_wdata = d_wd;
      MDB_in = rand_mdb ? 16'($urandom) : s_mdb;
      @(negedge clk);
      model_step();
      if (log_on && (fetch_gnt || data_gnt)) got_q.push_back(data_gnt);
      cyc++;
   endtask

   task automatic new_data();
      d_we = 1'($urandom); d_bw = 1'($urandom);
      d_addr = 16'($urandom); d_wd = 16'($urandom);
   endtask

   // Single directed data access; reports bus values seen and latencies.
   task automatic do_data(input logic we, input logic bw, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] mdb,
                          output logic [15:0] mab_o, output logic [15:0] mdb_o,
                          output logic [1:0] mwe_o, output int bus_n, output int lat,
                          output logic [15:0] rd);
      int gc;
      bit seen;
      f_pend = 0; d_pend = 1; d_we = we; d_bw = bw; d_addr = a; d_wd = wd;
      s_mdb = mdb; rand_mdb = 0;
      bus_n = 0; lat = -1; gc = -1; seen = 0;
      mab_o = 16'h0; mdb_o = 16'h0; mwe_o = 2'b00; rd = 16'h0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (data_gnt) gc = cyc - 1;
         if (mem_re || mem_we != 2'b00) begin
            bus_n++; mab_o = MAB; mdb_o = MDB_out; mwe_o = mem_we;
         end
         if (data_ack) begin
            seen = 1; lat = cyc - 1 - gc; rd = data_rdata; d_pend = 0;
         end
      end
      if (!seen) check_eq("data_timeout", 16'h1, 16'h0);
      d_pend = 0;
      tick();
   endtask

   initial begin
      logic [15:0] mab_o, mdb_o, rd;
      logic [1:0]  mwe_o;
      int          bus_n, lat, acks, k;

      s_rst = 1; f_pend = 0; d_pend = 0; d_we = 0; d_bw = 0;
      f_addr = 16'h0; d_addr = 16'h0; d_wd = 16'h0; s_mdb = 16'h0;
      rand_mdb = 0; log_on = 0; m_act = 0; m_streak = 0;
      e_frd = 16'h0; e_drd = 16'h0; m_cap = 16'h0;
      rst = 1; fetch_req = 0; data_req = 0; data_we = 0; data_bw = 0;
      fetch_addr = 0; data_addr = 0; data_wdata = 0; MDB_in = 0;

      tick(); tick();
      s_rst = 0;
      tick();
      check_eq("reset_MAB", MAB, 16'h0);
      check_eq("reset_busy", 16'(busy), 16'h0);

      // byte write to odd address
      do_data(1, 1, 16'h0201, 16'h00AB, 16'h0, mab_o, mdb_o, mwe_o, bus_n, lat, rd);
      check_eq("bw_MAB", mab_o, 16'h0201);
      check_eq("bw_MDB_out", mdb_o, 16'hABAB);
      check_eq("bw_mem_we", 16'(mwe_o), 16'h2);
      check_eq("bw_bus_cycles", 16'(bus_n), 16'(W + 1));
      check_eq("bw_ack_latency", 16'(lat), 16'(W + 2));
      // byte write to even address
      do_data(1, 1, 16'h0300, 16'h5A77, 16'h0, mab_o, mdb_o, mwe_o, bus_n, lat, rd);
      check_eq("bw_even_mem_we", 16'(mwe_o), 16'h1);
      check_eq("bw_even_MDB_out", mdb_o, 16'h7777);
      // byte read odd, word read from odd address
      do_data(0, 1, 16'h0201, 16'h0, 16'h1234, mab_o, mdb_o, mwe_o, bus_n, lat, rd);
      check_eq("br_rdata", rd, 16'h0012);
      do_data(0, 1, 16'h0200, 16'h0, 16'h1234, mab_o, mdb_o, mwe_o, bus_n, lat, rd);
      check_eq("br_even_rdata", rd, 16'h0034);
      do_data(0, 0, 16'h0201, 16'h0, 16'h1234, mab_o, mdb_o, mwe_o, bus_n, lat, rd);
      check_eq("wr_MAB", mab_o, 16'h0200);
      check_eq("wr_rdata", rd, 16'h1234);
      check_eq("wr_bus_cycles", 16'(bus_n), 16'(W + 1));
      do_data(1, 0, 16'h0401, 16'hBEEF, 16'h0, mab_o, mdb_o, mwe_o, bus_n, lat, rd);
      check_eq("ww_mem_we", 16'(mwe_o), 16'h3);
      check_eq("ww_MAB", mab_o, 16'h0400);
      check_eq("ww_keeps_rdata", data_rdata, 16'h1234);

      // fetch whose req drops right after grant still completes
      f_pend = 1; f_addr = 16'hC000; s_mdb = 16'h4031; acks = 0; k = 0;
      while (!fetch_gnt && k < 10) begin tick(); k++; end
      f_pend = 0;
      for (int i = 0; i < 8; i++) begin tick(); if (fetch_ack) acks++; end
      check_eq("drop_req_ack", 16'(acks), 16'h1);
      check_eq("fetch_rdata", fetch_rdata, 16'h4031);

      // reset during ACCESS aborts the access
      d_pend = 1; d_we = 0; d_bw = 0; d_addr = 16'h1000; k = 0;
      tick();
      while (!data_gnt && k < 10) begin tick(); k++; end
      tick();
      s_rst = 1; d_pend = 0;
      tick();
      s_rst = 0;
      tick();
      check_eq("abort_MAB", MAB, 16'h0);
      check_eq("abort_mem_re", 16'(mem_re), 16'h0);
      check_eq("abort_mem_we", 16'(mem_we), 16'h0);
      check_eq("abort_busy", 16'(busy), 16'h0);
      acks = 0;
      for (int i = 0; i < 8; i++) begin tick(); if (data_ack || fetch_ack) acks++; end
      check_eq("abort_no_ack", 16'(acks), 16'h0);

      // contention from a fresh reset: D,D,D,D,F,D,D,D,D,F
      s_rst = 1; tick(); s_rst = 0;
      exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      got_q.delete();
      rand_mdb = 1; log_on = 1;
      f_pend = 1; f_addr = 16'($urandom); d_pend = 1; new_data();
      k = 0;
      while (got_q.size() < 10 && k < 200) begin
         tick(); k++;
         if (fack_now) f_addr = 16'($urandom);
         if (dack_now) new_data();
      end
      log_on = 0;
      check_eq("gseq_len", 16'(got_q.size()), 16'd10);
      for (int i = 0; i < 10 && i < got_q.size(); i++)
         check_eq($sformatf("gseq_%0d", i), 16'(got_q[i]), 16'(exp_q[i]));
      f_pend = 0; d_pend = 0;
      for (int i = 0; i < 8; i++) tick();

      // randomized traffic at two load levels
      for (int ph = 0; ph < 2; ph++) begin
         int prob;
         prob = (ph == 0) ? 35 : 90;
         for (int i = 0; i < 1500; i++) begin
            tick();
            if (fack_now) f_pend = 0;
            if (dack_now) d_pend = 0;
            if (!f_pend && $urandom_range(0, 99) < prob) begin
               f_pend = 1; f_addr = 16'($urandom);
            end
            if (!d_pend && $urandom_range(0, 99) < prob) begin
               d_pend = 1; new_data();
            end
         end
         f_pend = 0; d_pend = 0;
         for (int i = 0; i < 10; i++) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences and shares the single MSP430 memory bus (MAB/MDB) between the pipeline's instruction-fetch port and its execute-stage data port.
- Arbitrates between the two requesters and drives address, byte enables and write data for each access.
- Inserts configurable wait states and returns read data with a one-cycle acknowledge.
- Sits between the pipeline and the memory model; the memory returns read data on MDB_in.

Parameters:
- WAIT_STATES, 0, extra cycles the bus is held per access (0..15).
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch_req is pending before fetch is forced (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request; hold with fetch_addr stable until fetch_ack
- fetch_addr  in  16  fetch word address
- fetch_gnt  out  1  one-cycle pulse, fetch access started
- fetch_ack  out  1  one-cycle pulse, fetch_rdata valid
- fetch_rdata  out  16  fetched word
- data_req  in  1  data request; hold with data_* stable until data_ack
- data_we  in  1  1=write, 0=read
- data_bw  in  1  1=byte, 0=word
- data_addr  in  16  data address
- data_wdata  in  16  write data; low byte used for byte writes
- data_gnt  out  1  one-cycle pulse, data access started
- data_ack  out  1  one-cycle pulse, write done / data_rdata valid
- data_rdata  out  16  read data; byte reads zero-extended
- MAB  out  16  memory address bus
- MDB_out  out  16  memory write data
- MDB_in  in  16  memory read data, valid while mem_re is high
- mem_re  out  1  read strobe
- mem_we  out  2  write byte enables, [1]=high/odd byte, [0]=low/even byte
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous):
  - State goes to IDLE and the streak counter clears.
  - All outputs are 0: MAB, MDB_out, mem_re, mem_we, both gnt/ack, both rdata, busy.
  - Reset asserted mid-access aborts the access: no ack, bus outputs 0 on the next cycle.
- FSM states IDLE, ACCESS, DONE:
  - IDLE: if any request is high, pick a winner, pulse its gnt, register MAB/MDB_out/mem_re/mem_we and load wait_cnt=WAIT_STATES, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: bus outputs held constant. If wait_cnt!=0, decrement it. If wait_cnt==0, capture MDB_in (read) and go to DONE.
  - DONE: bus outputs 0, winner's ack high for this one cycle, rdata valid, then go to IDLE.
- Latency: a request seen in IDLE at cycle T gives gnt at T, bus active T+1..T+1+WAIT_STATES, ack at T+2+WAIT_STATES. Minimum period is 3+WAIT_STATES cycles per access.
- Handshake:
  - The requester drops req, or presents a new request, in the cycle after ack.
  - req high in IDLE is always treated as a new request.
  - req deasserted before ack is a protocol violation; the access still completes and acks.
- Arbitration (in IDLE only):
  - Only one request high: grant it.
  - Both high: grant data, unless streak==MAX_DATA_STREAK, in which case grant fetch.
  - streak increments on each data grant while fetch_req is high.
  - streak clears on any fetch grant and on any data grant with fetch_req low.
- Address and width rules:
  - Fetch is always a word read.
  - Word accesses drive MAB = addr with bit0 forced to 0.
  - Word read: rdata = MDB_in. Word write: mem_we=2'b11, MDB_out=wdata.
  - Byte accesses drive MAB = addr unmodified.
  - Byte write: MDB_out={wdata[7:0],wdata[7:0]}, mem_we=addr[0]?2'b10:2'b01.
  - Byte read: rdata={8'h00, addr[0]?MDB_in[15:8]:MDB_in[7:0]}.
  - mem_re=~we; mem_we=0 on reads.
- rdata registers hold their last value until the next ack for that port.
- At most one of fetch_gnt/data_gnt, and at most one of fetch_ack/data_ack, is high in any cycle.

Test Plan:
- Fetch, WAIT_STATES=0: fetch_req with addr 0xC000, MDB_in=0x4031 -> fetch_gnt at T, MAB=0xC000 and mem_re=1 at T+1, fetch_ack at T+2 with fetch_rdata=0x4031.
- Byte write: data_we=1, data_bw=1, addr 0x0201, wdata 0x00AB -> MAB=0x0201, mem_we=2'b10, MDB_out=0xABAB for one cycle; data_ack two cycles after grant.
- Byte/word read: byte read at 0x0201 with MDB_in=0x1234 -> data_rdata=0x0012. Word read at 0x0201 -> MAB=0x0200, data_rdata=0x1234.
- Contention, MAX_DATA_STREAK=4: both requests held continuously (re-asserted after each ack) -> grant sequence D,D,D,D,F,D,D,D,D,F; never both gnt or both ack in one cycle.
- WAIT_STATES=2: single data read -> MAB held 3 cycles (T+1..T+3), ack at T+4, rdata equals MDB_in sampled at T+3.
- Reset mid-access: rst pulsed during ACCESS -> no ack ever asserted for that access; MAB/mem_re/mem_we/busy=0 on the cycle after rst; the next request behaves as from a fresh reset.
